// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receiver control stage:
//   - default frame timing constants (clock cycles per bit, data bits per frame)
//   - FSM state encoding for uart_rx_ctrl
//   - is_timed(): true for the states in which the bit timer runs
// -----------------------------------------------------------------------------
package uart_rx_pkg;

    localparam int DEF_CLKS_PER_BIT = 10;
    localparam int DEF_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START_CHK,
        SAMPLE,
        STOP_SAMPLE,
        CHK_STOP,
        WAIT_FE,
        LOAD
    } rx_state_e;

    // States that measure time on the serial line.
    function automatic logic is_timed(input rx_state_e s);
        return (s == START_CHK) || (s == SAMPLE) || (s == STOP_SAMPLE);
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// -----------------------------------------------------------------------------
// rx_bit_timer
// Free-running bit-period counter used both for the half-bit start check and
// for the full-bit data/stop sampling intervals.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-high reset
//   clear      in   synchronous clear to 0 (wins over enable)
//   enable     in   count one cycle
//   half_done  out  count is at CLKS_PER_BIT/2 - 1 while enabled
//   rollover   out  count is at CLKS_PER_BIT - 1 while enabled; wraps to 0
// -----------------------------------------------------------------------------
module rx_bit_timer
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT   // even, >= 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic half_done,
    output logic rollover
);

    localparam int              TW        = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]   HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0]   FULL_LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] r_count;

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples its inputs from the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= (r_count == FULL_LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign half_done = enable && (r_count == HALF_LAST);
    assign rollover  = enable && (r_count == FULL_LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// UART receiver control stage sitting in front of the stop-bit checker.
// Synchronises the line, validates the start bit at mid-bit, shifts data in
// LSB first, captures the stop bit, hands it to the checker and loads the
// receive buffer only when the checker reports no framing error.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous, active-high reset
//   serial_in      in   raw UART line, idle high, asynchronous to clk
//   framing_error  in   registered flag from the stop-bit checker
//   sbc_clear      out  one-cycle clear strobe to the checker
//   sbc_enable     out  one-cycle evaluate strobe to the checker
//   stop_bit       out  last captured stop-bit sample
//   rx_data        out  assembled data word (LSB received first)
//   load_buffer    out  one-cycle strobe: rx_data valid, frame good
// -----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,  // even, >= 8
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 framing_error,
    output logic                 sbc_clear,
    output logic                 sbc_enable,
    output logic                 stop_bit,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 load_buffer
);

    localparam int            BW       = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    // Line synchroniser and edge detect
    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    // Marks how many synchroniser stages hold real line samples since reset.
    // The reset value 1 in the flops must not look like a high line, otherwise
    // a line already low at reset release would read as a start edge.
    logic [2:0] r_valid;
    logic       w_start_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_valid <= '0;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_valid <= {r_valid[1:0], 1'b1};
        end
    end

    assign w_start_edge = r_valid[2] && r_prev && !r_sync2;

    // Bit timer
    rx_state_e r_state;
    logic      w_timer_en;
    logic      w_timer_clear;
    logic      w_half_done;
    logic      w_rollover;

    // Runs only in the timed states; restarts from 0 when the start bit has
    // been confirmed so the first data sample lands one full bit later.
    assign w_timer_en    = is_timed(r_state);
    assign w_timer_clear = !w_timer_en || ((r_state == START_CHK) && w_half_done);

    rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_timer_clear),
        .enable    (w_timer_en),
        .half_done (w_half_done),
        .rollover  (w_rollover)
    );

    // Control FSM with registered strobes
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_stop_bit;
    logic                 r_sbc_clear;
    logic                 r_sbc_enable;
    logic                 r_load;

    // NOTE: each strobe register defaults to 0 every cycle and is set only on
    // the transition into its state, so it is high for exactly the one cycle
    // spent in that state and never holds a stale value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_stop_bit   <= 1'b1;
            r_sbc_clear  <= 1'b0;
            r_sbc_enable <= 1'b0;
            r_load       <= 1'b0;
        end else begin
            r_sbc_clear  <= 1'b0;
            r_sbc_enable <= 1'b0;
            r_load       <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        r_state     <= CLEAR;
                        r_sbc_clear <= 1'b1;
                    end
                end

                CLEAR: begin
                    r_state <= START_CHK;
                end

                START_CHK: begin
                    // Mid-start-bit sample: a high line means it was a glitch.
                    if (w_half_done) begin
                        if (!r_sync2) begin
                            r_state   <= SAMPLE;
                            r_bit_cnt <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                SAMPLE: begin
                    if (w_rollover) begin
                        r_shift   <= {r_sync2, r_shift[DATA_BITS-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= STOP_SAMPLE;
                        end
                    end
                end

                STOP_SAMPLE: begin
                    if (w_rollover) begin
                        r_stop_bit   <= r_sync2;
                        r_state      <= CHK_STOP;
                        r_sbc_enable <= 1'b1;
                    end
                end

                CHK_STOP: begin
                    r_state <= WAIT_FE;
                end

                WAIT_FE: begin
                    if (framing_error) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= LOAD;
                        r_load  <= 1'b1;
                    end
                end

                LOAD: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sbc_clear   = r_sbc_clear;
    assign sbc_enable  = r_sbc_enable;
    assign load_buffer = r_load;
    assign stop_bit    = r_stop_bit;
    assign rx_data     = r_shift;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl with default parameters (10 clocks/bit,
// 8 data bits). A small stop-bit checker model drives framing_error.
// Cycle numbers are counted in rising edges; c0 is the cycle in which the
// bench drives the start-bit falling edge, so D = c0 + 2.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    localparam int N = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       serial_in;
    logic       framing_error;
    logic       sbc_clear;
    logic       sbc_enable;
    logic       stop_bit;
    logic [7:0] rx_data;
    logic       load_buffer;

    int checks = 0;
    int errors = 0;

    uart_rx_ctrl #(
        .CLKS_PER_BIT (N),
        .DATA_BITS    (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .framing_error (framing_error),
        .sbc_clear     (sbc_clear),
        .sbc_enable    (sbc_enable),
        .stop_bit      (stop_bit),
        .rx_data       (rx_data),
        .load_buffer   (load_buffer)
    );

    always #5 clk = ~clk;

    // Cycle counter: value n during the cycle following rising edge n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stop-bit checker model: cleared by sbc_clear, evaluates on sbc_enable.
    always @(posedge clk or posedge rst) begin
        if (rst)             framing_error <= 1'b0;
        else if (sbc_clear)  framing_error <= 1'b0;
        else if (sbc_enable) framing_error <= ~stop_bit;
    end

    // Strobe monitor, sampled on the falling edge.
    int       clr_cnt = 0, en_cnt = 0, ld_cnt = 0;
    int       clr_cyc = -1, en_cyc = -1;
    int       ld_cyc [8];
    logic [7:0] ld_data [8];
    int       strobe_viol = 0;
    logic     p_clr = 1'b0, p_en = 1'b0, p_ld = 1'b0;

    always @(negedge clk) begin
        if (sbc_clear) begin
            clr_cnt++;
            clr_cyc = cyc;
        end
        if (sbc_enable) begin
            en_cnt++;
            en_cyc = cyc;
        end
        if (load_buffer) begin
            if (ld_cnt < 8) begin
                ld_cyc[ld_cnt]  = cyc;
                ld_data[ld_cnt] = rx_data;
            end
            ld_cnt++;
        end
        if ((int'(sbc_clear) + int'(sbc_enable) + int'(load_buffer)) > 1 ||
            (sbc_clear && p_clr) || (sbc_enable && p_en) || (load_buffer && p_ld))
            strobe_viol++;
        p_clr = sbc_clear;
        p_en  = sbc_enable;
        p_ld  = load_buffer;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int frame_c0;

    // Drives one full frame (start, 8 data LSB first, stop), N cycles per bit,
    // and returns the line to idle high at cycle c0 + 10N.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        serial_in = 1'b0;
        frame_c0  = cyc;
        repeat (N) tick();
        for (int i = 0; i < 8; i++) begin
            serial_in = b[i];
            repeat (N) tick();
        end
        serial_in = stop;
        repeat (N) tick();
        serial_in = 1'b1;
    endtask

    int c0, c_a;
    int clr_b, en_b, ld_b;

    initial begin
        // Reset with idle line
        rst       = 1'b1;
        serial_in = 1'b1;
        repeat (3) tick();
        check("rst_sbc_clear",   32'(sbc_clear),   32'd0);
        check("rst_sbc_enable",  32'(sbc_enable),  32'd0);
        check("rst_load_buffer", 32'(load_buffer), 32'd0);
        check("rst_rx_data",     32'(rx_data),     32'h00);
        check("rst_stop_bit",    32'(stop_bit),    32'd1);
        check("rst_state",       32'(dut.r_state), 32'(IDLE));

        // Line held low through reset release and for 300 cycles: no start
        serial_in = 1'b0;
        tick();
        rst = 1'b0;
        repeat (300) tick();
        check("break_clr_cnt", 32'(clr_cnt), 32'd0);
        check("break_en_cnt",  32'(en_cnt),  32'd0);
        check("break_ld_cnt",  32'(ld_cnt),  32'd0);
        check("break_state",   32'(dut.r_state), 32'(IDLE));
        serial_in = 1'b1;
        repeat (10) tick();

        // Good frame 0xA5
        send_frame(8'hA5, 1'b1);
        repeat (3) tick();
        c0 = frame_c0;
        check("a5_clr_cycle", 32'(clr_cyc),   32'(c0 + 3));
        check("a5_en_cycle",  32'(en_cyc),    32'(c0 + 99));
        check("a5_ld_cnt",    32'(ld_cnt),    32'd1);
        check("a5_ld_cycle",  32'(ld_cyc[0]), 32'(c0 + 101));
        check("a5_ld_data",   32'(ld_data[0]), 32'hA5);
        check("a5_stop_bit",  32'(stop_bit),  32'd1);

        // Bad stop bit, frame 0x3C: no load, IDLE at D+99
        ld_b = ld_cnt;
        send_frame(8'h3C, 1'b0);
        tick();
        c0 = frame_c0;
        check("3c_state_d99", 32'(dut.r_state), 32'(IDLE));
        repeat (5) tick();
        check("3c_en_cycle", 32'(en_cyc),   32'(c0 + 99));
        check("3c_stop_bit", 32'(stop_bit), 32'd0);
        check("3c_no_load",  32'(ld_cnt),   32'(ld_b));
        check("3c_rx_data",  32'(rx_data),  32'h3C);

        // Reset mid-frame at D+40 while the line stays low past release
        clr_b = clr_cnt;
        en_b  = en_cnt;
        serial_in = 1'b0;
        c0 = cyc;
        repeat (42) tick();
        check("mid_rx_data_pre", 32'(rx_data), 32'h07);
        rst = 1'b1;
        #1;
        check("mid_sbc_clear",   32'(sbc_clear),   32'd0);
        check("mid_sbc_enable",  32'(sbc_enable),  32'd0);
        check("mid_load_buffer", 32'(load_buffer), 32'd0);
        check("mid_rx_data",     32'(rx_data),     32'h00);
        check("mid_stop_bit",    32'(stop_bit),    32'd1);
        check("mid_state",       32'(dut.r_state), 32'(IDLE));
        repeat (2) tick();
        rst = 1'b0;
        repeat (46) tick();
        serial_in = 1'b1;
        repeat (30) tick();
        check("mid_clr_cnt", 32'(clr_cnt), 32'(clr_b + 1));
        check("mid_en_cnt",  32'(en_cnt),  32'(en_b));
        check("mid_ld_cnt",  32'(ld_cnt),  32'(ld_b));
        check("mid_state_end", 32'(dut.r_state), 32'(IDLE));

        // Three-cycle low glitch
        clr_b = clr_cnt;
        serial_in = 1'b0;
        c0 = cyc;
        repeat (3) tick();
        serial_in = 1'b1;
        repeat (20) tick();
        check("glitch_clr_cnt",   32'(clr_cnt), 32'(clr_b + 1));
        check("glitch_clr_cycle", 32'(clr_cyc), 32'(c0 + 3));
        check("glitch_en_cnt",    32'(en_cnt),  32'(en_b));
        check("glitch_ld_cnt",    32'(ld_cnt),  32'(ld_b));
        check("glitch_state",     32'(dut.r_state), 32'(IDLE));

        // Back-to-back frames 0x00 then 0xFF
        ld_b = ld_cnt;
        send_frame(8'h00, 1'b1);
        c_a = frame_c0;
        send_frame(8'hFF, 1'b1);
        repeat (5) tick();
        check("b2b_ld_cnt", 32'(ld_cnt), 32'(ld_b + 2));
        if (ld_cnt >= ld_b + 2 && ld_b + 1 < 8) begin
            check("b2b_ld0_cycle", 32'(ld_cyc[ld_b]), 32'(c_a + 101));
            check("b2b_ld_gap",    32'(ld_cyc[ld_b + 1] - ld_cyc[ld_b]), 32'd100);
            check("b2b_ld0_data",  32'(ld_data[ld_b]),     32'h00);
            check("b2b_ld1_data",  32'(ld_data[ld_b + 1]), 32'hFF);
        end

        check("strobe_exclusive", 32'(strobe_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
